net_dm9k_target: RTL

//  Device-side responder for the DM9000-style parallel host bus (CS#/RD#/WR#/CMD, 16-bit data).

---
 rtl/net_dm9k_target_if.sv | 22 ++
 rtl/net_dm9k_target.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/net_dm9k_target_if.sv
// Host-side parallel bus of the DM9000-style target: strobes, command select,
// split data lanes with a tristate enable, and the interrupt line.
interface net_dm9k_target_if;
    logic        dm9k_cs_n;
    logic        dm9k_rd_n;
    logic        dm9k_we_n;
    logic        dm9k_cmd;
    logic [15:0] dm9k_data_i;
    logic [15:0] dm9k_data_o;
    logic        dm9k_data_t;
    logic        dm9k_int;

    modport master (
        output dm9k_cs_n, dm9k_rd_n, dm9k_we_n, dm9k_cmd, dm9k_data_i,
        input  dm9k_data_o, dm9k_data_t, dm9k_int
    );

    modport slave (
        input  dm9k_cs_n, dm9k_rd_n, dm9k_we_n, dm9k_cmd, dm9k_data_i,
        output dm9k_data_o, dm9k_data_t, dm9k_int
    );
endinterface

// File: rtl/net_dm9k_target.sv
// DM9000-style bus target: synchronises the asynchronous host strobes, decodes
// index/data cycles into a small register file, serves an RX word FIFO via
// MRCMD and emits MWCMD writes as single-cycle TX pulses.
module net_dm9k_target #(
    parameter int          RX_AW      = 4,
    parameter logic [15:0] VENDOR_ID  = 16'h0A46,
    parameter logic [15:0] PRODUCT_ID = 16'h9000
) (
    input  logic                clk_bus,
    input  logic                rst,
    net_dm9k_target_if.slave    bus,
    input  logic [15:0]         rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [15:0]         tx_data,
    output logic                tx_valid
);
    localparam logic [RX_AW:0] FULL_COUNT = {1'b1, {RX_AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, RD_DRIVE, RD_DONE} state_t;

    logic cs_s1, cs_s2, cs_d;
    logic rd_s1, rd_s2, rd_d;
    logic we_s1, we_s2, we_d;
    logic cmd_s1, cmd_s2, cmd_d;
    logic [15:0] data_s1, data_s2, data_d;

    state_t state, state_nxt;
    logic wr_commit, pop;
    logic rd_fall, rd_rise, we_rise;

    logic [7:0] index, ncr, imr;
    logic isr_pr;
    logic int_r;
    logic [15:0] rd_value, rd_mux;
    logic rd_pop_ok;

    logic [15:0] mem [FULL_COUNT];
    logic [RX_AW-1:0] wr_ptr, rd_ptr;
    logic [RX_AW:0] count;
    logic fifo_empty, push;
    logic reg_wr, ncr_flush, isr_clr;

    // Two-stage synchronisers for the strobes, an equal-depth pipe for cmd/data,
    // plus one extra stage (_d) that holds the previous synced value for edge
    // detection and the cmd/data seen in the last cycle before a strobe rise.
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            {cs_s1, cs_s2, cs_d}       <= 3'b111;
            {rd_s1, rd_s2, rd_d}       <= 3'b111;
            {we_s1, we_s2, we_d}       <= 3'b111;
            {cmd_s1, cmd_s2, cmd_d}    <= 3'b000;
            data_s1 <= '0;
            data_s2 <= '0;
            data_d  <= '0;
        end else begin
            cs_s1   <= bus.dm9k_cs_n;  cs_s2   <= cs_s1;   cs_d   <= cs_s2;
            rd_s1   <= bus.dm9k_rd_n;  rd_s2   <= rd_s1;   rd_d   <= rd_s2;
            we_s1   <= bus.dm9k_we_n;  we_s2   <= we_s1;   we_d   <= we_s2;
            cmd_s1  <= bus.dm9k_cmd;   cmd_s2  <= cmd_s1;  cmd_d  <= cmd_s2;
            data_s1 <= bus.dm9k_data_i; data_s2 <= data_s1; data_d <= data_s2;
        end
    end

    // A read starts only while selected; a write needs select and rd high in the
    // last low cycle of we, so overlapping rd/we strobes never commit a write.
    assign rd_fall = rd_d & ~rd_s2 & ~cs_s2;
    assign rd_rise = ~rd_d & rd_s2;
    assign we_rise = ~we_d & we_s2 & ~cs_d & rd_d;

    assign fifo_empty = (count == '0);
    assign rx_ready   = (count != FULL_COUNT);
    assign push       = rx_valid & rx_ready;

    // Bus-cycle state register.
    always_ff @(posedge clk_bus) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: reads take priority over writes; writes commit only when idle,
    // and the FIFO pop is deferred to the cycle after the read strobe releases.
    always_comb begin
        state_nxt = state;
        wr_commit = 1'b0;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_fall)      state_nxt = RD_DRIVE;
                else if (we_rise) wr_commit = 1'b1;
            end
            RD_DRIVE: if (rd_rise) state_nxt = RD_DONE;
            RD_DONE: begin
                state_nxt = IDLE;
                pop       = rd_pop_ok;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data selection for the current index; unmapped locations read zero.
    always_comb begin
        rd_mux = '0;
        if (!cmd_s2) begin
            rd_mux = {8'h00, index};
        end else begin
            case (index)
                8'h00:   rd_mux = {8'h00, ncr};
                8'h28:   rd_mux = {8'h00, VENDOR_ID[7:0]};
                8'h29:   rd_mux = {8'h00, VENDOR_ID[15:8]};
                8'h2A:   rd_mux = {8'h00, PRODUCT_ID[7:0]};
                8'h2B:   rd_mux = {8'h00, PRODUCT_ID[15:8]};
                8'hF2:   rd_mux = fifo_empty ? 16'h0000 : mem[rd_ptr];
                8'hFE:   rd_mux = {15'h0000, isr_pr};
                8'hFF:   rd_mux = {8'h00, imr};
                default: rd_mux = '0;
            endcase
        end
    end

    // Latch the read value at the start of a read so the bus holds it steady,
    // and remember whether releasing the strobe must pop the FIFO.
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            rd_value  <= '0;
            rd_pop_ok <= 1'b0;
        end else if (state == IDLE && rd_fall) begin
            rd_value  <= rd_mux;
            rd_pop_ok <= cmd_s2 && (index == 8'hF2) && !fifo_empty;
        end
    end

    assign bus.dm9k_data_t = (state != RD_DRIVE);
    assign bus.dm9k_data_o = (state == RD_DRIVE) ? rd_value : 16'h0000;

    assign reg_wr    = wr_commit & cmd_d;
    assign ncr_flush = reg_wr && (index == 8'h00) && data_d[0];
    assign isr_clr   = reg_wr && (index == 8'hFE) && data_d[0];

    // Index and register writes; NCR.RST is never stored so it reads back
    // cleared, and MWCMD turns each write into a one-cycle TX pulse.
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            index    <= '0;
            ncr      <= '0;
            imr      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (wr_commit && !cmd_d) index <= data_d[7:0];
            if (reg_wr) begin
                case (index)
                    8'h00: ncr <= {data_d[7:1], 1'b0};
                    8'hF8: begin
                        tx_data  <= data_d;
                        tx_valid <= 1'b1;
                    end
                    8'hFF: imr <= data_d[7:0];
                    default: ;
                endcase
            end
        end
    end

    // RX FIFO pointers and occupancy; a soft reset empties it outright.
    always_ff @(posedge clk_bus) begin
        if (rst || ncr_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // RX FIFO storage; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk_bus) begin
        if (push && !rst && !ncr_flush) mem[wr_ptr] <= rx_data;
    end

    // Packet-received status: a push beats a same-cycle write-one-to-clear.
    always_ff @(posedge clk_bus) begin
        if (rst || ncr_flush) isr_pr <= 1'b0;
        else if (push)        isr_pr <= 1'b1;
        else if (isr_clr)     isr_pr <= 1'b0;
    end

    // Registered interrupt output gated by the PRI mask bit.
    always_ff @(posedge clk_bus) begin
        if (rst) int_r <= 1'b0;
        else     int_r <= isr_pr & imr[0];
    end

    assign bus.dm9k_int = int_r;
endmodule
